// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg7_pkg;

  typedef logic [3:0] nibble_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam int DEFAULT_NUM_DIGITS  = 8;
  localparam int DEFAULT_REFRESH_DIV = 50000;

endpackage

// File: rtl/binary_to_7seg.sv
// Hex nibble to active-low seven-segment pattern, bit order gfedcba.
module binary_to_7seg
  import seg7_pkg::*;
(
  input  nibble_t    value,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_BLANK;
    unique case (value)
      4'h0: seg_n = 7'b1000000;
      4'h1: seg_n = 7'b1111001;
      4'h2: seg_n = 7'b0100100;
      4'h3: seg_n = 7'b0110000;
      4'h4: seg_n = 7'b0011001;
      4'h5: seg_n = 7'b0010010;
      4'h6: seg_n = 7'b0000010;
      4'h7: seg_n = 7'b1111000;
      4'h8: seg_n = 7'b0000000;
      4'h9: seg_n = 7'b0010000;
      4'hA: seg_n = 7'b0001000;
      4'hB: seg_n = 7'b0000011;
      4'hC: seg_n = 7'b1000110;
      4'hD: seg_n = 7'b0100001;
      4'hE: seg_n = 7'b0000110;
      4'hF: seg_n = 7'b0001110;
      default: seg_n = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scanner: one shared decoder stepped across the digits,
// with display updates deferred to frame boundaries and optional leading-zero blanking.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = DEFAULT_NUM_DIGITS,
  parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    blank_lz,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  output logic [6:0]              seg_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_done
);

  localparam int PRE_W  = $clog2(REFRESH_DIV);
  localparam int IDX_W  = $clog2(NUM_DIGITS);
  localparam int WORD_W = 4 * NUM_DIGITS;

  logic [PRE_W-1:0]      pre_q, pre_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [WORD_W-1:0]     disp_q, disp_d;
  logic [WORD_W-1:0]     shadow_q, shadow_d;
  logic                  pending_q, pending_d;
  logic                  wrap_dly_q, wrap_dly_d;
  logic [6:0]            seg_n_q, seg_n_d;
  logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
  logic                  frame_done_q, frame_done_d;

  logic                  tick;
  logic                  wrap;
  nibble_t               nib [NUM_DIGITS];
  nibble_t               cur_nib;
  logic [NUM_DIGITS-1:0] upper_zero;
  logic                  cur_blank;
  logic [6:0]            dec_seg;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_nib
    assign nib[g] = disp_q[4*g +: 4];
  end

  assign cur_nib = nib[idx_q];

  binary_to_7seg u_dec (
    .value (cur_nib),
    .seg_n (dec_seg)
  );

  always_comb begin
    tick = enable && (pre_q == PRE_W'(REFRESH_DIV - 1));
    wrap = tick && (idx_q == IDX_W'(NUM_DIGITS - 1));

    pre_d = pre_q;
    if (tick)        pre_d = '0;
    else if (enable) pre_d = pre_q + PRE_W'(1);

    idx_d = idx_q;
    if (wrap)      idx_d = '0;
    else if (tick) idx_d = idx_q + IDX_W'(1);

    // A load landing on the wrap cycle bypasses the shadow so the newest value wins.
    shadow_d  = shadow_q;
    disp_d    = disp_q;
    pending_d = pending_q;
    if (load && wrap) begin
      shadow_d  = value_in;
      disp_d    = value_in;
      pending_d = 1'b0;
    end else if (load) begin
      shadow_d  = value_in;
      pending_d = 1'b1;
    end else if (wrap && pending_q) begin
      disp_d    = shadow_q;
      pending_d = 1'b0;
    end

    upper_zero[NUM_DIGITS-1] = (nib[NUM_DIGITS-1] == 4'h0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      upper_zero[i] = upper_zero[i+1] && (nib[i] == 4'h0);
    end
    cur_blank = blank_lz && (idx_q != '0) && upper_zero[idx_q];

    // Blanked digits keep their anode asserted so every slot has the same duty cycle.
    seg_n_d = SEG_BLANK;
    an_n_d  = '1;
    if (enable) begin
      an_n_d  = ~(NUM_DIGITS'(1) << idx_q);
      seg_n_d = cur_blank ? SEG_BLANK : dec_seg;
    end

    // Delayed one extra cycle so the pulse lines up with digit 0 appearing on an_n.
    wrap_dly_d   = wrap;
    frame_done_d = wrap_dly_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q        <= '0;
      idx_q        <= '0;
      disp_q       <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      wrap_dly_q   <= 1'b0;
      seg_n_q      <= SEG_BLANK;
      an_n_q       <= '1;
      frame_done_q <= 1'b0;
    end else begin
      pre_q        <= pre_d;
      idx_q        <= idx_d;
      disp_q       <= disp_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      wrap_dly_q   <= wrap_dly_d;
      seg_n_q      <= seg_n_d;
      an_n_q       <= an_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg_n      = seg_n_q;
  assign an_n       = an_n_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with NUM_DIGITS=8 and REFRESH_DIV=4.
module tb_seg7_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        blank_lz;
  logic        load;
  logic [31:0] value_in;
  logic [6:0]  seg_n;
  logic [7:0]  an_n;
  logic        frame_done;

  int vec_count;
  int miss_count;

  seg7_scan_ctrl #(
    .NUM_DIGITS  (8),
    .REFRESH_DIV (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .blank_lz   (blank_lz),
    .load       (load),
    .value_in   (value_in),
    .seg_n      (seg_n),
    .an_n       (an_n),
    .frame_done (frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Steps to the next falling edge until frame_done is seen; that cycle shows digit 0.
  task automatic wait_frame_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) seen = 1'b1;
    end
    vec_count++;
    if (!seen) begin
      miss_count++;
      $display("FAIL %s frame_done_timeout got 0 want 1 within 40 cycles", name);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; enable = 1'b0; blank_lz = 1'b0; load = 1'b0; value_in = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vec_count++; if (seg_n !== 7'h7F) begin miss_count++; $display("FAIL reset_seg got %h want 7f", seg_n); end
    vec_count++; if (an_n !== 8'hFF) begin miss_count++; $display("FAIL reset_an got %h want ff", an_n); end
    vec_count++; if (frame_done !== 1'b0) begin miss_count++; $display("FAIL reset_fd got %b want 0", frame_done); end

    rst_n = 1'b1; enable = 1'b1;
    #1;
    vec_count++; if (an_n !== 8'hFF) begin miss_count++; $display("FAIL release_dark_an got %h want ff", an_n); end
    @(negedge clk);
    vec_count++; if (an_n !== 8'hFE) begin miss_count++; $display("FAIL first_lit_an got %h want fe", an_n); end
    vec_count++; if (seg_n !== 7'h40) begin miss_count++; $display("FAIL first_lit_seg got %h want 40", seg_n); end

    repeat (20) @(negedge clk);
    vec_count++; if (an_n !== 8'hDF) begin miss_count++; $display("FAIL midscan_an got %h want df", an_n); end

    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    vec_count++; if (seg_n !== 7'h7F) begin miss_count++; $display("FAIL async_reset_seg got %h want 7f", seg_n); end
    vec_count++; if (an_n !== 8'hFF) begin miss_count++; $display("FAIL async_reset_an got %h want ff", an_n); end
    vec_count++; if (frame_done !== 1'b0) begin miss_count++; $display("FAIL async_reset_fd got %b want 0", frame_done); end
    @(negedge clk);
  endtask

  task automatic test_full_frame();
    logic [6:0] tbl [8];
    logic [6:0] e_seg;
    logic [7:0] e_an;
    logic       e_fd;
    int         d;
    tbl = '{7'h21, 7'h46, 7'h03, 7'h08, 7'h19, 7'h30, 7'h24, 7'h79};
    rst_n = 1'b1; load = 1'b1; value_in = 32'h1234ABCD;
    @(negedge clk);
    load = 1'b0;
    wait_frame_done("full_frame");
    for (int j = 0; j <= 32; j++) begin
      if (j > 0) @(negedge clk);
      d     = (j / 4) % 8;
      e_seg = tbl[d];
      e_an  = ~(8'b1 << d);
      e_fd  = (j == 0 || j == 32);
      vec_count++; if (seg_n !== e_seg) begin miss_count++; $display("FAIL full_frame_seg j=%0d got %h want %h", j, seg_n, e_seg); end
      vec_count++; if (an_n !== e_an) begin miss_count++; $display("FAIL full_frame_an j=%0d got %h want %h", j, an_n, e_an); end
      vec_count++; if (frame_done !== e_fd) begin miss_count++; $display("FAIL full_frame_fd j=%0d got %b want %b", j, frame_done, e_fd); end
    end
  endtask

  task automatic test_frame_boundary();
    logic [6:0] e_seg;
    logic [7:0] e_an;
    int         d;
    load = 1'b1; value_in = 32'h11111111;
    @(negedge clk);
    load = 1'b0;
    wait_frame_done("boundary_setup");
    repeat (13) @(negedge clk);
    load = 1'b1; value_in = 32'h22222222;
    @(negedge clk);
    load = 1'b0;
    for (int j = 14; j <= 32; j++) begin
      if (j > 14) @(negedge clk);
      d     = (j / 4) % 8;
      e_seg = (j == 32) ? 7'h24 : 7'h79;
      e_an  = ~(8'b1 << d);
      vec_count++; if (seg_n !== e_seg) begin miss_count++; $display("FAIL boundary_seg j=%0d got %h want %h", j, seg_n, e_seg); end
      vec_count++; if (an_n !== e_an) begin miss_count++; $display("FAIL boundary_an j=%0d got %h want %h", j, an_n, e_an); end
    end

    repeat (28) @(negedge clk);
    load = 1'b1; value_in = 32'h44444444;
    @(negedge clk);
    value_in = 32'h66666666;
    @(negedge clk);
    value_in = 32'h55555555;
    @(negedge clk);
    load = 1'b0;
    vec_count++; if (seg_n !== 7'h24) begin miss_count++; $display("FAIL wrapload_old_seg got %h want 24", seg_n); end
    vec_count++; if (an_n !== 8'h7F) begin miss_count++; $display("FAIL wrapload_old_an got %h want 7f", an_n); end
    @(negedge clk);
    vec_count++; if (frame_done !== 1'b1) begin miss_count++; $display("FAIL wrapload_fd got %b want 1", frame_done); end
    vec_count++; if (seg_n !== 7'h12) begin miss_count++; $display("FAIL wrapload_new_seg got %h want 12", seg_n); end
    vec_count++; if (an_n !== 8'hFE) begin miss_count++; $display("FAIL wrapload_new_an got %h want fe", an_n); end
    wait_frame_done("wrapload_next");
    vec_count++; if (seg_n !== 7'h12) begin miss_count++; $display("FAIL wrapload_stale_seg got %h want 12", seg_n); end
  endtask

  task automatic test_blanking();
    logic [6:0] e_seg;
    logic [7:0] e_an;
    int         d;
    blank_lz = 1'b1; load = 1'b1; value_in = 32'h00000050;
    @(negedge clk);
    load = 1'b0;
    wait_frame_done("blank_setup");
    for (int j = 0; j < 32; j++) begin
      if (j > 0) @(negedge clk);
      d     = j / 4;
      e_seg = (d == 0) ? 7'h40 : (d == 1) ? 7'h12 : 7'h7F;
      e_an  = ~(8'b1 << d);
      vec_count++; if (seg_n !== e_seg) begin miss_count++; $display("FAIL blank50_seg j=%0d got %h want %h", j, seg_n, e_seg); end
      vec_count++; if (an_n !== e_an) begin miss_count++; $display("FAIL blank50_an j=%0d got %h want %h", j, an_n, e_an); end
    end

    wait_frame_done("blank_mid");
    load = 1'b1; value_in = 32'h00000000;
    @(negedge clk);
    load = 1'b0;
    wait_frame_done("blank_zero");
    for (int j = 0; j <= 30; j++) begin
      if (j > 0) @(negedge clk);
      d     = j / 4;
      e_seg = (d == 0 || j == 30) ? 7'h40 : 7'h7F;
      e_an  = ~(8'b1 << d);
      vec_count++; if (seg_n !== e_seg) begin miss_count++; $display("FAIL blank0_seg j=%0d got %h want %h", j, seg_n, e_seg); end
      vec_count++; if (an_n !== e_an) begin miss_count++; $display("FAIL blank0_an j=%0d got %h want %h", j, an_n, e_an); end
      if (j == 29) blank_lz = 1'b0;
    end
  endtask

  task automatic test_enable_gating();
    logic [6:0] e_seg;
    logic [7:0] e_an;
    load = 1'b1; value_in = 32'hFEDCBA98;
    @(negedge clk);
    load = 1'b0;
    wait_frame_done("gate_setup");
    repeat (8) @(negedge clk);
    vec_count++; if (an_n !== 8'hFB) begin miss_count++; $display("FAIL gate_pre_an got %h want fb", an_n); end
    enable = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (k == 3) begin load = 1'b1; value_in = 32'h77777777; end
      @(negedge clk);
      load = 1'b0;
      vec_count++; if (seg_n !== 7'h7F) begin miss_count++; $display("FAIL gate_dark_seg k=%0d got %h want 7f", k, seg_n); end
      vec_count++; if (an_n !== 8'hFF) begin miss_count++; $display("FAIL gate_dark_an k=%0d got %h want ff", k, an_n); end
      vec_count++; if (frame_done !== 1'b0) begin miss_count++; $display("FAIL gate_dark_fd k=%0d got %b want 0", k, frame_done); end
    end
    enable = 1'b1;
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      e_an  = (k < 3) ? 8'hFB : 8'hF7;
      e_seg = (k < 3) ? 7'h08 : 7'h03;
      vec_count++; if (seg_n !== e_seg) begin miss_count++; $display("FAIL gate_resume_seg k=%0d got %h want %h", k, seg_n, e_seg); end
      vec_count++; if (an_n !== e_an) begin miss_count++; $display("FAIL gate_resume_an k=%0d got %h want %h", k, an_n, e_an); end
    end
    wait_frame_done("gate_load");
    vec_count++; if (seg_n !== 7'h78) begin miss_count++; $display("FAIL gate_load_seg got %h want 78", seg_n); end
    vec_count++; if (an_n !== 8'hFE) begin miss_count++; $display("FAIL gate_load_an got %h want fe", an_n); end
  endtask

  initial begin
    vec_count  = 0;
    miss_count = 0;
    $display("[TB] seg7_scan_ctrl directed run starting");
    test_reset();
    test_full_frame();
    test_frame_boundary();
    test_blanking();
    test_enable_gating();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
